// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath constants and types for the 8-bit CPU
package cpu_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational register file read port
// Zero-register forcing wins over the write bypass, so r0 always reads 0x00.
module regfile_read_port
  import cpu_pkg::*;
(
  input  reg_addr_t                 addr,
  input  data_t [NUM_REGS-1:0]      regs,
  input  logic                      byp_valid,
  input  reg_addr_t                 byp_addr,
  input  data_t                     byp_data,
  output data_t                     read_data
);

  always_comb begin
    read_data = regs[addr];
    if (byp_valid && (byp_addr == addr)) begin
      read_data = byp_data;
    end
    if (addr == ZERO_REG) begin
      read_data = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x8 register file, two read ports, one write port
// Optional same-cycle write-to-read bypass: define REGFILE_WRITE_BYPASS_EN.
module register_file
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      write_enable,
  input  reg_addr_t rs,
  input  reg_addr_t rt,
  input  reg_addr_t rd,
  input  data_t     write_data,
  output data_t     read_data1,
  output data_t     read_data2
);

  data_t [NUM_REGS-1:0] regs;
  logic                 byp_valid;

  // Reset beats a simultaneous write; writes to r0 are dropped so it stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else if (write_enable && (rd != ZERO_REG)) begin
      regs[rd] <= write_data;
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  assign byp_valid = write_enable && (rd != ZERO_REG);
`else
  assign byp_valid = 1'b0;
`endif

  regfile_read_port u_port1 (
    .addr      (rs),
    .regs      (regs),
    .byp_valid (byp_valid),
    .byp_addr  (rd),
    .byp_data  (write_data),
    .read_data (read_data1)
  );

  regfile_read_port u_port2 (
    .addr      (rt),
    .regs      (regs),
    .byp_valid (byp_valid),
    .byp_addr  (rd),
    .byp_data  (write_data),
    .read_data (read_data2)
  );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file
module tb_register_file;
  import cpu_pkg::*;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic      clk = 1'b0;
  logic      rst;
  logic      write_enable;
  reg_addr_t rs, rt, rd;
  data_t     write_data;
  data_t     read_data1, read_data2;

  always #5 clk = ~clk;

  register_file dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .write_data   (write_data),
    .read_data1   (read_data1),
    .read_data2   (read_data2)
  );

  typedef struct {
    logic      rst;
    logic      we;
    reg_addr_t rd;
    data_t     wd;
    reg_addr_t rs;
    reg_addr_t rt;
    data_t     exp1;
    data_t     exp2;
  } vec_t;

  typedef struct {
    string name;
    data_t exp1;
    data_t exp2;
  } sb_t;

  vec_t  vecs[12];
  sb_t   sb_q[$];
  data_t model[NUM_REGS];
  int    tests = 0;
  int    fails = 0;

  task automatic check(input string name, input data_t act, input data_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  function automatic data_t model_read(input reg_addr_t a, input logic we,
                                       input reg_addr_t wa, input data_t wd);
    if (a == ZERO_REG) return '0;
    if (BYPASS && we && (wa != ZERO_REG) && (wa == a)) return wd;
    return model[a];
  endfunction

  task automatic model_edge(input logic r, input logic we, input reg_addr_t wa, input data_t wd);
    if (r) begin
      for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    end else if (we && (wa != ZERO_REG)) begin
      model[wa] = wd;
    end
  endtask

  // Drive a cycle's inputs just after the edge, push expectations, compare at negedge.
  task automatic drive_and_check(input string name, input logic r, input logic we,
                                 input reg_addr_t wa, input data_t wd,
                                 input reg_addr_t a1, input reg_addr_t a2,
                                 input data_t e1, input data_t e2);
    sb_t s, p;
    @(posedge clk);
    #1;
    rst = r; write_enable = we; rd = wa; write_data = wd; rs = a1; rt = a2;
    s.name = name; s.exp1 = e1; s.exp2 = e2;
    sb_q.push_back(s);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: scoreboard empty got 0 entries expected 1", name);
    end else begin
      p = sb_q.pop_front();
      check({p.name, "_rd1"}, read_data1, p.exp1);
      check({p.name, "_rd2"}, read_data2, p.exp2);
    end
    model_edge(r, we, wa, wd);
  endtask

  initial begin
    data_t e1, e2;
    rst = 1'b1; write_enable = 1'b0; rd = '0; write_data = '0; rs = '0; rt = '0;

    // Non-bypass expectations, read before each vector's own edge.
    vecs[0]  = '{0, 1, 5'd5,  8'hEF, 5'd5,  5'd5,  8'h00, 8'h00};
    vecs[1]  = '{0, 0, 5'd5,  8'h12, 5'd5,  5'd5,  8'hEF, 8'hEF};
    vecs[2]  = '{0, 1, 5'd0,  8'hFF, 5'd5,  5'd0,  8'hEF, 8'h00};
    vecs[3]  = '{0, 0, 5'd0,  8'h00, 5'd0,  5'd0,  8'h00, 8'h00};
    vecs[4]  = '{0, 1, 5'd1,  8'h11, 5'd5,  5'd1,  8'hEF, 8'h00};
    vecs[5]  = '{0, 1, 5'd31, 8'hAA, 5'd1,  5'd31, 8'h11, 8'h00};
    vecs[6]  = '{0, 0, 5'd0,  8'h00, 5'd1,  5'd31, 8'h11, 8'hAA};
    vecs[7]  = '{0, 1, 5'd1,  8'h22, 5'd1,  5'd1,  8'h11, 8'h11};
    vecs[8]  = '{0, 0, 5'd0,  8'h00, 5'd1,  5'd31, 8'h22, 8'hAA};
    vecs[9]  = '{1, 1, 5'd7,  8'h55, 5'd1,  5'd31, 8'h22, 8'hAA};
    vecs[10] = '{0, 0, 5'd0,  8'h00, 5'd7,  5'd1,  8'h00, 8'h00};
    vecs[11] = '{0, 0, 5'd0,  8'h00, 5'd31, 5'd5,  8'h00, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;

    for (int i = 0; i < NUM_REGS; i++) begin
      rs = reg_addr_t'(i);
      rt = reg_addr_t'(NUM_REGS - 1 - i);
      #1;
      check($sformatf("reset_r%0d_rd1", i), read_data1, 8'h00);
      check($sformatf("reset_r%0d_rd2", i), read_data2, 8'h00);
    end

    for (int i = 0; i < 12; i++) begin
      e1 = vecs[i].exp1;
      e2 = vecs[i].exp2;
      if (BYPASS && vecs[i].we && !vecs[i].rst && vecs[i].rd != ZERO_REG) begin
        if (vecs[i].rs == vecs[i].rd) e1 = vecs[i].wd;
        if (vecs[i].rt == vecs[i].rd) e2 = vecs[i].wd;
      end
      drive_and_check($sformatf("vec%0d", i), vecs[i].rst, vecs[i].we, vecs[i].rd,
                      vecs[i].wd, vecs[i].rs, vecs[i].rt, e1, e2);
    end

    // New value visible within the cycle right after the write edge.
    drive_and_check("rdw_pre", 1'b0, 1'b1, 5'd9, 8'h3C, 5'd9, 5'd9,
                    BYPASS ? 8'h3C : 8'h00, BYPASS ? 8'h3C : 8'h00);
    @(posedge clk);
    #1;
    check("rdw_post_rd1", read_data1, 8'h3C);
    check("rdw_post_rd2", read_data2, 8'h3C);
    write_enable = 1'b0;

    // Random traffic against the behavioural model.
    for (int i = 0; i < 200; i++) begin
      logic      r, we;
      reg_addr_t wa, a1, a2;
      data_t     wd;
      r  = ($urandom_range(0, 15) == 0);
      we = $urandom_range(0, 1);
      wa = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      wd = data_t'($urandom_range(0, 255));
      a1 = ($urandom_range(0, 3) == 0) ? wa : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      drive_and_check($sformatf("rand%0d", i), r, we, wa, wd, a1, a2,
                      model_read(a1, we, wa, wd), model_read(a2, we, wa, wd));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- General-purpose register file for the 8-bit microprocessor datapath.
- 32 entries × 8 bits, addressed MIPS-style:
  - two combinational read ports (rs, rt);
  - one synchronous write port (rd).
- Register 0 is hard-wired to zero.
- Sits between instruction decode and the ALU; write-back drives the write port.

Parameters:
- DATA_W, 8, width of each register and of every data port.
- ADDR_W, 5, width of each register address.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes occur on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- write_enable  input  1  when high, write_data is stored into register rd at the rising edge.
- rs  input  ADDR_W  read address for port 1.
- rt  input  ADDR_W  read address for port 2.
- rd  input  ADDR_W  write address.
- write_data  input  DATA_W  data to write.
- read_data1  output  DATA_W  contents of register rs.
- read_data2  output  DATA_W  contents of register rt.

Behaviour:
- Storage: NUM_REGS registers of DATA_W bits.
- Reset:
  - rst high at a rising edge clears every register to 0.
  - Reset has priority over a simultaneous write.
  - Outputs therefore read 0x00 from the cycle after reset.
- Write:
  - At a rising edge with rst=0 and write_enable=1, reg[rd] <= write_data.
  - rd=0 is ignored; register 0 is never modified.
  - write_enable=0 leaves all registers unchanged.
- Read:
  - Purely combinational, zero latency.
  - read_data1 = (rs==0) ? 0 : reg[rs]; read_data2 likewise with rt.
  - rs and rt may be equal; both ports then return the same value.
- Read-during-write, same address, without the optional feature:
  - The read port returns the old value until the rising edge.
  - The new value is visible immediately after the edge, within the same cycle.
- X-free: every output is driven to a defined value at all times after the first reset.
- Address range is always fully populated (5 bits → 32 entries); there are no out-of-range addresses.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - When write_enable=1, rd!=0 and rs==rd, read_data1 = write_data combinationally, in the same cycle before the edge.
  - Same rule for read_data2 when rt==rd.
  - rd=0 is never bypassed; reads of register 0 stay 0x00.
- Not defined: reads reflect stored contents only, as described in Behaviour.

Decomposition:
- Shared package `cpu_pkg` holds:
  - constants DATA_W=8, ADDR_W=5, NUM_REGS=32, ZERO_REG=5'd0;
  - typedefs `data_t` (logic [DATA_W-1:0]) and `reg_addr_t` (logic [ADDR_W-1:0]).
- One natural sub-module: `regfile_read_port`, instantiated twice.
  - Inputs: address, register array, optional bypass inputs.
  - Contains the zero-register mux and bypass logic, so both ports are structurally identical.

Test Plan:
- Reset: assert rst for one edge, then read rs=0..31 and rt=0..31 → all read_data1/read_data2 = 0x00.
- Basic write/read:
  - Drive we=1, rd=5, wd=0xEF for one edge, then we=0.
  - rs=5, rt=5 → read_data1 = read_data2 = 0xEF.
- Zero register:
  - Drive we=1, rd=0, wd=0xFF for one edge.
  - rs=0, rt=0 → both outputs 0x00.
- Write-enable gating:
  - After the 0xEF write, drive we=0, rd=5, wd=0x12 for one edge → rs=5 still returns 0xEF.
- Dual-port independence plus same-cycle read/write:
  - Write r1=0x11 and r31=0xAA; then rs=1, rt=31 → 0x11 and 0xAA.
  - With we=1, rd=1, wd=0x22 and rs=1 before the edge:
    - read_data1 = 0x11 without REGFILE_WRITE_BYPASS_EN;
    - read_data1 = 0x22 with it;
    - after the edge, 0x22 in both builds.
- Reset priority: with we=1, rd=7, wd=0x55 and rst=1 on the same edge → rs=7 returns 0x00.
